// File: rtl/shift_seq_ctrl_if.sv
// shift_seq_ctrl_if: command and response handshake channels between host and sequencer
interface shift_seq_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  modport master (
    output cmd_valid, cmd_op, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data
  );
  modport slave (
    input  cmd_valid, cmd_op, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: sequences transmit/receive commands onto an exclusively owned parallel-load shift register
module shift_seq_ctrl #(
  parameter int   WIDTH      = 4,
  parameter int   GAP_CYCLES = 1,
  parameter logic FILL       = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  shift_seq_ctrl_if.slave  bus,
  input  logic             ser_in,
  output logic             ser_out,
  output logic             ser_en,
  output logic             reg_l,
  output logic             reg_sh,
  output logic             reg_si,
  output logic [WIDTH-1:0] reg_d,
  input  logic [WIDTH-1:0] reg_q,
  output logic             busy
);
  localparam int CMAX = WIDTH > GAP_CYCLES ? WIDTH : GAP_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, RESP, GAP} state_t;
  // with no gap configured, finished commands return straight to IDLE
  localparam state_t AFTER = GAP_CYCLES == 0 ? IDLE : GAP;
  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             op;
  logic [WIDTH-1:0] data;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      op    <= 1'b0;
      data  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == IDLE && bus.cmd_valid) begin
        op   <= bus.cmd_op;
        data <= bus.cmd_data;
      end
    end
  end
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    bus.cmd_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.rsp_data  = '0;
    reg_l         = 1'b0;
    reg_sh        = 1'b0;
    reg_si        = 1'b0;
    reg_d         = '0;
    ser_en        = 1'b0;
    ser_out       = 1'b0;
    unique case (state)
      IDLE: begin
        bus.cmd_ready = 1'b1;
        state_nxt     = bus.cmd_valid ? LOAD : IDLE;
      end
      LOAD: begin
        reg_l     = 1'b1;
        reg_d     = op ? '0 : data;
        state_nxt = SHIFT;
        cnt_nxt   = '0;
      end
      SHIFT: begin
        reg_sh  = 1'b1;
        reg_si  = op ? ser_in : FILL;
        ser_en  = !op;
        ser_out = !op && reg_q[0];
        cnt_nxt = cnt + 1'b1;
        if (cnt == CW'(WIDTH - 1)) begin
          state_nxt = op ? RESP : AFTER;
          cnt_nxt   = '0;
        end
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        bus.rsp_data  = reg_q;
        state_nxt     = bus.rsp_ready ? AFTER : RESP;
      end
      GAP: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == CW'(GAP_CYCLES - 1)) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end
  assign busy = state != IDLE;
endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb_shift_seq_ctrl: directed and randomized checks of shift_seq_ctrl against a behavioural model
module tb_shift_seq_ctrl;
  localparam int W = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  int n_chk = 0;
  int n_fail = 0;
  shift_seq_ctrl_if #(.WIDTH(W)) if0 ();
  shift_seq_ctrl_if #(.WIDTH(W)) if1 ();
  logic si0, so0, se0, l0, sh0, rsi0, busy0;
  logic si1, so1, se1, l1, sh1, rsi1, busy1;
  logic [W-1:0] d0, d1;
  logic [W-1:0] q0 = '0;
  logic [W-1:0] q1 = '0;
  shift_seq_ctrl #(.WIDTH(W), .GAP_CYCLES(1), .FILL(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n), .bus(if0), .ser_in(si0), .ser_out(so0), .ser_en(se0),
    .reg_l(l0), .reg_sh(sh0), .reg_si(rsi0), .reg_d(d0), .reg_q(q0), .busy(busy0));
  shift_seq_ctrl #(.WIDTH(W), .GAP_CYCLES(0), .FILL(1'b0)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(if1), .ser_in(si1), .ser_out(so1), .ser_en(se1),
    .reg_l(l1), .reg_sh(sh1), .reg_si(rsi1), .reg_d(d1), .reg_q(q1), .busy(busy1));
  // shift register models: L loads D, Sh shifts right taking SI into the MSB, L wins
  always @(posedge clk) if (l0) q0 <= d0; else if (sh0) q0 <= {rsi0, q0[W-1:1]};
  always @(posedge clk) if (l1) q1 <= d1; else if (sh1) q1 <= {rsi1, q1[W-1:1]};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_tx0(input logic [W-1:0] w, input bit hold, input logic [W-1:0] nw);
    int n, nb;
    logic [W-1:0] got;
    if0.cmd_valid = 1'b1; if0.cmd_op = 1'b0; if0.cmd_data = w;
    #1 chk("tx_ready", if0.cmd_ready, 1);
    n = 0; nb = 0; got = '0;
    do begin
      @(negedge clk); n++;
      if0.cmd_valid = hold;
      if0.cmd_data = hold ? nw : W'($urandom);
      if0.cmd_op = hold ? 1'b0 : 1'($urandom);
      #1;
      if (n == 1) begin chk("tx_load", l0, 1); chk("tx_d", d0, w); end
      chk("tx_l_sh_excl", l0 & sh0, 0);
      if (se0) begin if (nb < W) got[nb] = so0; nb++; end
    end while (!if0.cmd_ready && n < 20);
    chk("tx_latency", n - 1, 1 + W + 1);
    chk("tx_nbits", nb, W);
    chk("tx_word", got, w);
    chk("tx_q_final", q0, 0);
  endtask

  task automatic run_rx0(input logic [W-1:0] bits, input int stall);
    int n;
    if0.cmd_valid = 1'b1; if0.cmd_op = 1'b1; if0.cmd_data = W'($urandom); if0.rsp_ready = 1'b0;
    #1 chk("rx_ready", if0.cmd_ready, 1);
    n = 0;
    do begin
      @(negedge clk); n++;
      if0.cmd_valid = 1'b0;
      si0 = (n >= 2 && n <= W + 1) ? bits[n-2] : 1'($urandom);
      #1;
      if (n == 1) begin chk("rx_load", l0, 1); chk("rx_d_zero", d0, 0); end
      chk("rx_ser_en", se0, 0);
    end while (!if0.rsp_valid && n < 20);
    chk("rx_latency", n - 1, 1 + W);
    for (int s = 0; s <= stall; s++) begin
      if (s > 0) begin @(negedge clk); #1; end
      chk("rx_valid_hold", if0.rsp_valid, 1);
      chk("rx_data_hold", if0.rsp_data, bits);
    end
    if0.rsp_ready = 1'b1;
    #1 chk("rx_data_accept", if0.rsp_data, bits);
    @(negedge clk); if0.rsp_ready = 1'b0;
    #1 chk("rx_valid_drop", if0.rsp_valid, 0);
    chk("rx_data_zero", if0.rsp_data, 0);
    chk("rx_gap_busy", busy0, 1);
    @(negedge clk);
    #1 chk("rx_idle_ready", if0.cmd_ready, 1);
  endtask

  initial begin
    logic [W-1:0] w, r;
    int n, nb, nv;
    logic [W-1:0] got;
    if0.cmd_valid = 1'b0; if0.cmd_op = 1'b0; if0.cmd_data = '0; if0.rsp_ready = 1'b0;
    if1.cmd_valid = 1'b0; if1.cmd_op = 1'b0; if1.cmd_data = '0; if1.rsp_ready = 1'b0;
    si0 = 1'b0; si1 = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_cmd_ready", if0.cmd_ready, 1);
    chk("rst_busy", busy0, 0);
    chk("rst_reg_l", l0, 0);
    chk("rst_reg_sh", sh0, 0);
    chk("rst_reg_si", rsi0, 0);
    chk("rst_reg_d", d0, 0);
    chk("rst_ser_en", se0, 0);
    chk("rst_ser_out", so0, 0);
    chk("rst_rsp_valid", if0.rsp_valid, 0);
    chk("rst_rsp_data", if0.rsp_data, 0);
    rst_n = 1'b1;
    @(negedge clk);
    run_tx0(4'b1101, 1'b0, 4'b0000);
    run_rx0(4'b0011, 3);
    run_tx0(4'b1101, 1'b1, 4'b0011);
    run_tx0(4'b0011, 1'b0, 4'b0000);
    // asynchronous reset in the middle of a transmit
    if0.cmd_valid = 1'b1; if0.cmd_op = 1'b0; if0.cmd_data = 4'b0110;
    @(negedge clk); if0.cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1 chk("mid_shift_active", sh0, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_sh", sh0, 0);
    chk("mid_rst_ser_en", se0, 0);
    chk("mid_rst_busy", busy0, 0);
    chk("mid_rst_ready", if0.cmd_ready, 1);
    rst_n = 1'b1;
    run_tx0(4'b1010, 1'b0, 4'b0000);
    for (int i = 0; i < 8; i++) begin
      if ($urandom_range(1) == 1) run_tx0(W'($urandom), 1'b0, 4'b0000);
      else run_rx0(W'($urandom), int'($urandom_range(3)));
    end
    // zero-gap build: TX with changing cmd_data and a pending RX offer
    w = W'($urandom); r = W'($urandom);
    if1.cmd_valid = 1'b1; if1.cmd_op = 1'b0; if1.cmd_data = w; if1.rsp_ready = 1'b1;
    #1 chk("g0_ready", if1.cmd_ready, 1);
    n = 0; nb = 0; got = '0;
    do begin
      @(negedge clk); n++;
      if1.cmd_op = 1'b1; if1.cmd_data = W'($urandom); si1 = 1'($urandom);
      #1;
      chk("g0_l_sh_excl", l1 & sh1, 0);
      if (se1) begin if (nb < W) got[nb] = so1; nb++; end
    end while (!if1.cmd_ready && n < 20);
    chk("g0_tx_latency", n - 1, 1 + W);
    chk("g0_tx_nbits", nb, W);
    chk("g0_tx_word", got, w);
    n = 0; nv = 0;
    do begin
      @(negedge clk); n++;
      if1.cmd_valid = 1'b0;
      si1 = (n >= 2 && n <= W + 1) ? r[n-2] : 1'($urandom);
      #1;
      if (n == 1) begin chk("g0_rx_load", l1, 1); chk("g0_rx_d", d1, 0); end
      chk("g0_rx_l_sh_excl", l1 & sh1, 0);
      if (if1.rsp_valid) begin nv++; chk("g0_rx_data", if1.rsp_data, r); end
    end while (!if1.cmd_ready && n < 20);
    chk("g0_rx_latency", n - 1, 1 + W + 1);
    chk("g0_rx_nvalid", nv, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/shift_seq_ctrl.md
Name: shift_seq_ctrl

Overview:
Sequencer for the parallel-load shift register (ports L, Sh, SI, D, Q). It accepts transmit or receive commands over a valid/ready handshake. Transmit loads a word and shifts it out LSB-first. Receive clears the register, shifts in WIDTH serial bits and returns the captured word over a valid/ready response channel. It sits between a host-side command source and one shift register instance, which it owns exclusively.

Parameters:
WIDTH, 4, shift register width in bits; must be 2 or more
GAP_CYCLES, 1, idle cycles inserted after each command before cmd_ready reasserts; 0 is legal
FILL, 0, value driven on reg_si during transmit shifts

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  reset; asynchronous, active-low
cmd_valid  input  1  command offered
cmd_ready  output  1  controller can accept a command
cmd_op  input  1  0 = transmit, 1 = receive
cmd_data  input  WIDTH  transmit word (ignored for receive)
ser_in  input  1  serial receive data
ser_out  output  1  serial transmit bit
ser_en  output  1  ser_out valid this cycle
reg_l  output  1  to register L (parallel load)
reg_sh  output  1  to register Sh (shift)
reg_si  output  1  to register SI
reg_d  output  WIDTH  to register D
reg_q  input  WIDTH  from register Q
rsp_valid  output  1  received word available
rsp_data  output  WIDTH  received word
rsp_ready  input  1  consumer accepts response
busy  output  1  high in every state except IDLE

Behaviour:
- Register contract: L loads D; Sh shifts right with Q[WIDTH-1] taking SI and Q[0] falling off; L has priority. The controller never asserts reg_l and reg_sh together.
- FSM states: IDLE, LOAD, SHIFT, RESP, GAP. State, bit counter, latched op and latched data are registers.
- Reset, asynchronous: state=IDLE, counter=0, latched op/data=0. Outputs: cmd_ready=1, busy=0, reg_l=0, reg_sh=0, reg_si=0, reg_d=0, ser_en=0, ser_out=0, rsp_valid=0, rsp_data=0.
- IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, latch cmd_op and cmd_data, then go to LOAD. cmd_ready=0 in all other states; cmd_valid is ignored there.
- LOAD, one cycle: reg_l=1. reg_d = latched data for transmit, 0 for receive. Next state is SHIFT with counter=0.
- SHIFT, exactly WIDTH cycles: reg_sh=1.
  - Transmit: reg_si=FILL, ser_en=1, ser_out=reg_q[0], so bit k appears in shift cycle k, LSB first.
  - Receive: reg_si=ser_in (combinational), ser_en=0, ser_out=0. The first received bit ends in Q[0].
  - Counter increments each cycle. After the cycle with counter=WIDTH-1: transmit goes to GAP, or to IDLE if GAP_CYCLES=0; receive goes to RESP.
- RESP, receive only: rsp_valid=1, rsp_data=reg_q; the register holds because L=Sh=0. Stay until rsp_ready=1. rsp_ready high in the first RESP cycle completes in that cycle. Then go to GAP, or to IDLE if GAP_CYCLES=0.
- GAP: GAP_CYCLES cycles with all register controls low, then IDLE.
- Outside their active states: reg_d=0, reg_si=0, rsp_data=0.
- Latency:
  - Transmit: accept edge to cmd_ready high = 1+WIDTH+GAP_CYCLES cycles.
  - Receive: 1+WIDTH cycles to rsp_valid, plus response stall cycles, plus GAP_CYCLES.
- Back-to-back: cmd_valid held high is accepted in the first IDLE cycle; no extra bubble.
- Reset mid-operation: return to IDLE immediately and drop all controls. Register contents are don't-care. Any pending response is discarded.
- cmd_data/cmd_op changes after acceptance have no effect.

Test Plan:
1. Assert rst_n=0 mid-run, then release -> all outputs at reset values; cmd_ready=1, busy=0.
2. WIDTH=4, GAP=1, FILL=0: TX cmd_data=4'b1101 -> one cycle with reg_l=1 and reg_d=1101; four reg_sh cycles with ser_out=1,0,1,1; reg_q ends 0000; cmd_ready high 6 cycles after accept.
3. RX with ser_in=1,1,0,0 during the shift cycles -> rsp_valid after 5 cycles with rsp_data=4'b0011. Hold rsp_ready=0 for 3 cycles -> rsp_valid and rsp_data stable; accepted when rsp_ready=1.
4. cmd_valid held high with TX 1101 then TX 0011 -> second accepted exactly 6 cycles after the first; ser_out stream 1,0,1,1,(gap),1,1,0,0.
5. rst_n pulsed low after 2 transmit shifts -> state IDLE asynchronously; reg_sh and ser_en drop immediately; a following TX 1010 serializes 0,1,0,1 correctly.
6. GAP_CYCLES=0 build: change cmd_data while busy and offer RX during TX -> RX not accepted until IDLE; transmitted bits match the originally latched word; reg_l and reg_sh never high together.
